// File: rtl/nmr_vote_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nmr_vote_ctrl : triple-replica command voter with fault masking and slew    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nmr_vote_ctrl #(
  parameter int CMD_W    = 4,
  parameter int N_CH     = 2,
  parameter int FAULT_TH = 3,
  parameter int STEP_SH  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr_fault,
  input  logic [3*N_CH*CMD_W-1:0]   cmd_i,
  output logic [N_CH*CMD_W-1:0]     cmd_o,
  output logic [2:0]                fault_o,
  output logic [2:0]                fail_o,
  output logic [1:0]                mode_o,
  output logic                      no_major_o
);

  localparam int c_CNT_W = $clog2(FAULT_TH + 1);

  typedef enum logic [1:0] {
    S_SIMPLEX  = 2'd0,
    S_VOTE     = 2'd1,
    S_DEGRADED = 2'd2,
    S_SAFE     = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_settle, w_settle_nxt;
  logic [2:0]          r_fault, r_fail;
  logic [c_CNT_W-1:0]  r_cnt     [3];
  logic [c_CNT_W-1:0]  w_cnt_inc [3];
  logic [CMD_W-1:0]    w_rep     [3][N_CH];
  logic [CMD_W-1:0]    w_tgt     [N_CH];
  logic [1:0]          w_ha, w_hb;
  logic                w_agree, w_eval;
  logic [2:0]          w_mis, w_hit, w_fail_nxt;
  logic [1:0]          w_nf;

  for (genvar r = 0; r < 3; r++) begin : g_rep
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign w_rep[r][c] = cmd_i[(r*N_CH+c)*CMD_W +: CMD_W];
    end
  end

  // Healthy pair used in DEGRADED: the two lowest-index non-failed replicas.
  always_comb begin
    w_ha = 2'd0;
    w_hb = 2'd1;
    if (r_fail[0]) begin
      w_ha = 2'd1;
      w_hb = 2'd2;
    end else if (r_fail[1]) begin
      w_ha = 2'd0;
      w_hb = 2'd2;
    end
  end

  always_comb begin
    w_agree = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (w_rep[w_ha][c] != w_rep[w_hb][c]) w_agree = 1'b0;
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_tgt[c] = '0;
      case (r_state)
        S_SIMPLEX: begin
          if (!r_fail[0])      w_tgt[c] = w_rep[0][c];
          else if (!r_fail[1]) w_tgt[c] = w_rep[1][c];
          else if (!r_fail[2]) w_tgt[c] = w_rep[2][c];
        end
        S_VOTE: w_tgt[c] = (w_rep[0][c] & w_rep[1][c]) |
                           (w_rep[0][c] & w_rep[2][c]) |
                           (w_rep[1][c] & w_rep[2][c]);
        S_DEGRADED: w_tgt[c] = w_agree ? w_rep[w_ha][c] : cmd_o[c*CMD_W +: CMD_W];
        default: w_tgt[c] = '0;
      endcase
    end
  end

  assign no_major_o = (r_state == S_DEGRADED) && !w_agree;
  assign w_eval     = ((r_state == S_VOTE) || (r_state == S_DEGRADED)) && !r_settle;

  always_comb begin
    w_mis = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_rep[r][c] != w_tgt[c]) w_mis[r] = 1'b1;
      end
    end
    w_mis = w_mis & ~r_fail & {3{w_eval}};
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_cnt_inc[r] = (r_cnt[r] == c_CNT_W'(FAULT_TH)) ? r_cnt[r] : r_cnt[r] + c_CNT_W'(1);
      w_hit[r]     = w_mis[r] && (w_cnt_inc[r] == c_CNT_W'(FAULT_TH));
    end
  end

  // A clear on the same edge as a threshold hit wins.
  assign w_fail_nxt = clr_fault ? 3'b000 : (r_fail | w_hit);
  assign w_nf       = {1'b0, w_fail_nxt[0]} + {1'b0, w_fail_nxt[1]} + {1'b0, w_fail_nxt[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        if (clr_fault || (r_state == S_SIMPLEX) || !w_mis[r]) r_cnt[r] <= '0;
        else                                                  r_cnt[r] <= w_cnt_inc[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 3'b000;
      r_fail  <= 3'b000;
    end else begin
      r_fault <= w_mis;
      r_fail  <= w_fail_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_SIMPLEX;
      r_settle <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = 1'b0;
    if (!en) begin
      w_state_nxt = S_SIMPLEX;
    end else if (clr_fault) begin
      w_state_nxt  = S_VOTE;
      w_settle_nxt = 1'b1;
    end else begin
      case (r_state)
        S_SIMPLEX: begin
          w_settle_nxt = 1'b1;
          if (w_nf == 2'd0)      w_state_nxt = S_VOTE;
          else if (w_nf == 2'd1) w_state_nxt = S_DEGRADED;
          else                   w_state_nxt = S_SAFE;
        end
        S_VOTE: begin
          if (w_nf == 2'd1)      w_state_nxt = S_DEGRADED;
          else if (w_nf >= 2'd2) w_state_nxt = S_SAFE;
        end
        S_DEGRADED: begin
          if (w_nf >= 2'd2) w_state_nxt = S_SAFE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Per-channel slew limiter; the minimum step of one LSB guarantees convergence.
  for (genvar c = 0; c < N_CH; c++) begin : g_slew
    logic        [CMD_W-1:0] r_cmd;
    logic signed [CMD_W:0]   w_diff, w_step_sh, w_step;

    assign w_diff    = $signed({1'b0, w_tgt[c]}) - $signed({1'b0, r_cmd});
    assign w_step_sh = w_diff >>> STEP_SH;

    always_comb begin
      w_step = w_step_sh;
      if ((w_step_sh == '0) && (w_diff != '0))
        w_step = w_diff[CMD_W] ? '1 : {{CMD_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cmd <= '0;
      else     r_cmd <= r_cmd + w_step[CMD_W-1:0];
    end

    assign cmd_o[c*CMD_W +: CMD_W] = r_cmd;
  end

  assign fault_o = r_fault;
  assign fail_o  = r_fail;
  assign mode_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_nmr_vote_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nmr_vote_ctrl : bench for nmr_vote_ctrl (STEP_SH=1 and STEP_SH=0 copies) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_nmr_vote_ctrl;

  localparam int CW = 4;
  localparam int NC = 2;
  localparam int TH = 3;

  logic             clk = 1'b0;
  logic             rst, en, clr_fault;
  logic [3*NC*CW-1:0] cmd_i;
  logic [NC*CW-1:0] cmd_o   [2];
  logic [2:0]       fault_o [2];
  logic [2:0]       fail_o  [2];
  logic [1:0]       mode_o  [2];
  logic             no_major_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nmr_vote_ctrl #(.CMD_W(CW), .N_CH(NC), .FAULT_TH(TH), .STEP_SH(1)) u_dut_sh1 (
    .clk(clk), .rst(rst), .en(en), .clr_fault(clr_fault), .cmd_i(cmd_i),
    .cmd_o(cmd_o[0]), .fault_o(fault_o[0]), .fail_o(fail_o[0]),
    .mode_o(mode_o[0]), .no_major_o(no_major_o[0]));

  nmr_vote_ctrl #(.CMD_W(CW), .N_CH(NC), .FAULT_TH(TH), .STEP_SH(0)) u_dut_sh0 (
    .clk(clk), .rst(rst), .en(en), .clr_fault(clr_fault), .cmd_i(cmd_i),
    .cmd_o(cmd_o[1]), .fault_o(fault_o[1]), .fail_o(fail_o[1]),
    .mode_o(mode_o[1]), .no_major_o(no_major_o[1]));

  // Reference model state, one copy per instance (mode: 0 simplex .. 3 safe).
  int m_cmd   [2][NC];
  int m_fail  [2][3];
  int m_cnt   [2][3];
  int m_fault [2][3];
  int m_mode  [2];
  int m_settle[2];

  function automatic int shift_of(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int rep(int r, int c);
    return int'(cmd_i >> ((r*NC + c)*CW)) & ((1 << CW) - 1);
  endfunction

  function automatic int first_healthy(int k);
    int h = -1;
    for (int r = 2; r >= 0; r--) if (m_fail[k][r] == 0) h = r;
    return h;
  endfunction

  function automatic bit pair_agree(int k);
    int h[$];
    bit ok = 1'b1;
    for (int r = 0; r < 3; r++) if (m_fail[k][r] == 0) h.push_back(r);
    if (h.size() >= 2)
      for (int c = 0; c < NC; c++) if (rep(h[0], c) != rep(h[1], c)) ok = 1'b0;
    return ok;
  endfunction

  function automatic int target(int k, int c);
    int v = 0;
    int votes;
    int h;
    case (m_mode[k])
      0: begin
        h = first_healthy(k);
        v = (h < 0) ? 0 : rep(h, c);
      end
      1: begin
        for (int b = 0; b < CW; b++) begin
          votes = 0;
          for (int r = 0; r < 3; r++) votes += (rep(r, c) >> b) & 1;
          if (votes >= 2) v += (1 << b);
        end
      end
      2: v = pair_agree(k) ? rep(first_healthy(k), c) : m_cmd[k][c];
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_step(int k);
    int t[NC];
    bit mis[3];
    int nf, diff, step, om;
    om = m_mode[k];
    for (int c = 0; c < NC; c++) t[c] = target(k, c);
    for (int r = 0; r < 3; r++) begin
      mis[r] = 1'b0;
      if ((om == 1 || om == 2) && m_settle[k] == 0 && m_fail[k][r] == 0)
        for (int c = 0; c < NC; c++) if (rep(r, c) != t[c]) mis[r] = 1'b1;
    end
    nf = 0;
    for (int r = 0; r < 3; r++) begin
      if (clr_fault || om == 0 || !mis[r]) m_cnt[k][r] = 0;
      else if (m_cnt[k][r] < TH) m_cnt[k][r]++;
      if (clr_fault) m_fail[k][r] = 0;
      else if (mis[r] && m_cnt[k][r] == TH) m_fail[k][r] = 1;
      m_fault[k][r] = int'(mis[r]);
      nf += m_fail[k][r];
    end
    m_settle[k] = 0;
    if (!en) m_mode[k] = 0;
    else if (clr_fault) begin m_mode[k] = 1; m_settle[k] = 1; end
    else if (om == 0) begin m_mode[k] = (nf == 0) ? 1 : (nf == 1) ? 2 : 3; m_settle[k] = 1; end
    else if (om == 1 && nf >= 1) m_mode[k] = (nf == 1) ? 2 : 3;
    else if (om == 2 && nf >= 2) m_mode[k] = 3;
    for (int c = 0; c < NC; c++) begin
      diff = t[c] - m_cmd[k][c];
      step = diff >>> shift_of(k);
      if (step == 0 && diff != 0) step = (diff > 0) ? 1 : -1;
      m_cmd[k][c] += step;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0;
        m_settle[k] = 0;
        for (int c = 0; c < NC; c++) m_cmd[k][c] = 0;
        for (int r = 0; r < 3; r++) begin
          m_fail[k][r] = 0; m_cnt[k][r] = 0; m_fault[k][r] = 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int vec3(int k, bit is_fail);
    int v = 0;
    for (int r = 0; r < 3; r++) v |= (is_fail ? m_fail[k][r] : m_fault[k][r]) << r;
    return v;
  endfunction

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++)
        chk($sformatf("u%0d.cmd_ch%0d", k, c), int'(cmd_o[k][c*CW +: CW]), m_cmd[k][c]);
      chk($sformatf("u%0d.fault", k), int'(fault_o[k]), vec3(k, 1'b0));
      chk($sformatf("u%0d.fail", k), int'(fail_o[k]), vec3(k, 1'b1));
      chk($sformatf("u%0d.mode", k), int'(mode_o[k]), m_mode[k]);
      chk($sformatf("u%0d.no_major", k), int'(no_major_o[k]),
          int'(m_mode[k] == 2 && !pair_agree(k)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch0(input int a0, input int a1, input int a2);
    cmd_i = '0;
    cmd_i[(0*NC)*CW +: CW] = a0[CW-1:0];
    cmd_i[(1*NC)*CW +: CW] = a1[CW-1:0];
    cmd_i[(2*NC)*CW +: CW] = a2[CW-1:0];
  endtask

  function automatic int ch0(int k);
    return int'(cmd_o[k][CW-1:0]);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clr_fault = 1'b0; cmd_i = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("lit.reset_mode", int'(mode_o[0]), 0);
    chk("lit.reset_cmd", int'(cmd_o[0]), 0);
    chk("lit.reset_fail", int'(fail_o[0]), 0);

    // All replicas agree: VOTE after one edge, no faults.
    set_ch0(5, 5, 5); en = 1'b1;
    tick();
    chk("lit.vote_mode_sh0", int'(mode_o[1]), 1);
    chk("lit.vote_mode_sh1", int'(mode_o[0]), 1);
    tick();
    chk("lit.pass_cmd_sh0", ch0(1), 5);
    chk("lit.pass_fault_sh0", int'(fault_o[1]), 0);
    repeat (4) tick();
    chk("lit.ramp_cmd_sh1", ch0(0), 5);

    // Replica 2 disagrees for FAULT_TH cycles and gets latched failed.
    set_ch0(5, 5, 9);
    tick();
    chk("lit.r2_fault", int'(fault_o[0]), 3'b100);
    chk("lit.r2_not_failed_yet", int'(fail_o[0]), 0);
    repeat (2) tick();
    chk("lit.r2_failed", int'(fail_o[0]), 3'b100);
    chk("lit.degraded", int'(mode_o[0]), 2);
    tick();
    chk("lit.degraded_fault_clr", int'(fault_o[0]), 0);
    chk("lit.degraded_cmd", ch0(0), 5);

    // Healthy pair disagrees: hold, then agree at 7.
    set_ch0(5, 6, 9);
    #1;
    chk("lit.no_major_on", int'(no_major_o[0]), 1);
    tick();
    chk("lit.hold_cmd", ch0(0), 5);
    chk("lit.hold_fault_r1", int'(fault_o[0]), 3'b010);
    set_ch0(7, 7, 9);
    #1;
    chk("lit.no_major_off", int'(no_major_o[0]), 0);
    repeat (2) tick();
    chk("lit.agree_cmd_sh1", ch0(0), 7);
    chk("lit.agree_cmd_sh0", ch0(1), 7);

    // Second replica fails -> SAFE, ramp 8,4,2,1,0.
    set_ch0(8, 8, 9);
    repeat (3) tick();
    chk("lit.pre_safe_cmd", ch0(0), 8);
    set_ch0(8, 6, 9);
    repeat (3) tick();
    chk("lit.safe_mode", int'(mode_o[0]), 3);
    chk("lit.safe_fail", int'(fail_o[0]), 3'b110);
    chk("lit.safe_ramp0", ch0(0), 8);
    tick(); chk("lit.safe_ramp1", ch0(0), 4);
    tick(); chk("lit.safe_ramp2", ch0(0), 2);
    tick(); chk("lit.safe_ramp3", ch0(0), 1);
    tick(); chk("lit.safe_ramp4", ch0(0), 0);

    // clr_fault in SAFE: back to VOTE with a settle cycle.
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk("lit.clr_fail", int'(fail_o[0]), 0);
    chk("lit.clr_mode", int'(mode_o[0]), 1);
    tick();
    chk("lit.settle_no_fault", int'(fault_o[0]), 0);
    tick();
    chk("lit.vote_no_replica_match", int'(fault_o[0]), 3'b110);
    tick();
    // clr_fault on the same edge as a double threshold hit.
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk("lit.clr_wins_fail", int'(fail_o[0]), 0);
    chk("lit.clr_wins_mode", int'(mode_o[0]), 1);
    tick();
    chk("lit.clr_wins_settle", int'(fault_o[0]), 0);

    // Fail replica 2, then drop en: SIMPLEX keeps the fail flag.
    set_ch0(5, 5, 9);
    repeat (3) tick();
    chk("lit.refail_r2", int'(fail_o[0]), 3'b100);
    en = 1'b0;
    tick();
    chk("lit.simplex_mode", int'(mode_o[0]), 0);
    chk("lit.simplex_fail_kept", int'(fail_o[0]), 3'b100);
    set_ch0(3, 5, 9);
    tick();
    chk("lit.simplex_pass_sh0", ch0(1), 3);

    // Asynchronous reset mid-ramp.
    set_ch0(15, 15, 15); en = 1'b1;
    tick();
    chk("lit.midramp_nonzero", int'(ch0(0) != 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("lit.async_rst_cmd", int'(cmd_o[0]), 0);
    chk("lit.async_rst_mode", int'(mode_o[0]), 0);
    chk("lit.async_rst_fail", int'(fail_o[0]), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
